// File: rtl/blink_seq_pkg.sv
// Shared types and constants for the blink pattern sequencer.
package blink_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [23:0] DEFAULT_DIV = 24'h7a1200;
  localparam int unsigned MIN_DIV     = 2;

endpackage

// File: rtl/blink_tick_gen.sv
// Bit-period divider: pulses tick during the last cycle of each div-cycle bit period.
module blink_tick_gen #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] div,
  output logic             tick
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] last_count;

  assign last_count = div - 1'b1;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = (count_q == last_count) ? '0 : count_q + 1'b1;
    end
    // Registered tick lines up with the cycle in which count sits at div-1.
    tick_d = enable && !clear && (count_d == last_count);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/blink_seq.sv
// Programmable LED blink sequencer: config port, IDLE/RUN/DONE FSM, bit index and pass counter.
// Define BLINK_SEQ_ACTIVE_LOW_EN to drive an active-low LED (led_out inverted).
module blink_seq #(
  parameter int unsigned      WIDTH       = 24,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(blink_seq_pkg::DEFAULT_DIV),
  parameter int unsigned      PAT_LEN     = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [WIDTH-1:0]   cfg_div,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic [7:0]         cfg_repeat,
  input  logic               start,
  input  logic               stop,
  output logic               busy,
  output logic               done,
  output logic               tick,
  output logic               led_out
);

  import blink_seq_pkg::*;

  localparam int unsigned      IDX_W     = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PAT_LEN - 1);
  localparam logic [WIDTH-1:0] MIN_DIV_W = WIDTH'(MIN_DIV);

`ifdef BLINK_SEQ_ACTIVE_LOW_EN
  localparam logic LED_INV = 1'b1;
`else
  localparam logic LED_INV = 1'b0;
`endif

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   div_q, div_d;
  logic [PAT_LEN-1:0] pattern_q, pattern_d;
  logic [7:0]         repeat_q, repeat_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         pass_q, pass_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               led_q, led_d;

  logic               handshake;
  logic [PAT_LEN-1:0] pattern_sel;
  logic [IDX_W-1:0]   idx_inc;
  logic [7:0]         pass_inc;
  logic               tick_w;
  logic               cnt_clear;
  logic               cnt_en;

  assign handshake = (state_q == IDLE) && cfg_valid;
  assign idx_inc   = idx_q + 1'b1;
  assign pass_inc  = pass_q + 8'd1;
  // A start coinciding with a handshake must play the freshly offered pattern.
  assign pattern_sel = handshake ? cfg_pattern : pattern_q;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    pattern_d = pattern_q;
    repeat_d  = repeat_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    led_d     = led_q;

    case (state_q)
      IDLE: begin
        if (handshake) begin
          div_d     = (cfg_div < MIN_DIV_W) ? MIN_DIV_W : cfg_div;
          pattern_d = cfg_pattern;
          repeat_d  = cfg_repeat;
        end
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
          pass_d  = '0;
          busy_d  = 1'b1;
          led_d   = pattern_sel[0] ^ LED_INV;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          led_d   = LED_INV;
        end else if (tick_w) begin
          if (idx_q == LAST_IDX) begin
            idx_d  = '0;
            pass_d = pass_inc;
            if ((repeat_q != 8'd0) && (pass_inc == repeat_q)) begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              led_d   = LED_INV;
            end else begin
              led_d = pattern_q[0] ^ LED_INV;
            end
          end else begin
            idx_d = idx_inc;
            led_d = pattern_q[idx_inc] ^ LED_INV;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        led_d   = LED_INV;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      div_q     <= DEFAULT_DIV;
      pattern_q <= '1;
      repeat_q  <= '0;
      idx_q     <= '0;
      pass_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      led_q     <= LED_INV;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      pattern_q <= pattern_d;
      repeat_q  <= repeat_d;
      idx_q     <= idx_d;
      pass_q    <= pass_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      led_q     <= led_d;
    end
  end

  // The counter is held clear on every cycle that is not a continuing RUN cycle.
  assign cnt_en    = (state_q == RUN);
  assign cnt_clear = (state_q != RUN) || (state_d != RUN);

  blink_tick_gen #(
    .WIDTH (WIDTH)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .div     (div_q),
    .tick    (tick_w)
  );

  assign cfg_ready = (state_q == IDLE);
  assign busy      = busy_q;
  assign done      = done_q;
  assign tick      = tick_w;
  assign led_out   = led_q;

endmodule

// File: tb/tb_blink_seq.sv
// Directed self-checking bench for blink_seq.
module tb_blink_seq;

`ifdef BLINK_SEQ_ACTIVE_LOW_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [23:0] cfg_div;
  logic [7:0]  cfg_pattern;
  logic [7:0]  cfg_repeat;
  logic        start;
  logic        stop;
  logic        busy;
  logic        done;
  logic        tick;
  logic        led_out;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  blink_seq dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_div     (cfg_div),
    .cfg_pattern (cfg_pattern),
    .cfg_repeat  (cfg_repeat),
    .start       (start),
    .stop        (stop),
    .busy        (busy),
    .done        (done),
    .tick        (tick),
    .led_out     (led_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [23:0] d, input logic [7:0] p, input logic [7:0] r);
    cfg_div     = d;
    cfg_pattern = p;
    cfg_repeat  = r;
    cfg_valid   = 1'b1;
    step();
    cfg_valid   = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_div = '0; cfg_pattern = '0; cfg_repeat = '0;
    #2;
    tests_run++;
    if ({cfg_ready, busy, done, tick, led_out} !== {1'b1, 1'b0, 1'b0, 1'b0, INV}) begin
      tests_failed++;
      $display("FAIL reset_outputs got rdy/busy/done/tick/led=%b want %b",
               {cfg_ready, busy, done, tick, led_out}, {1'b1, 1'b0, 1'b0, 1'b0, INV});
    end
    step(); step();
    reset_n = 1'b1;
    step();
    tests_run++;
    if ({cfg_ready, busy, led_out} !== {1'b1, 1'b0, INV}) begin
      tests_failed++;
      $display("FAIL reset_release got rdy/busy/led=%b want %b",
               {cfg_ready, busy, led_out}, {1'b1, 1'b0, INV});
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_pattern();
    logic [7:0] pat;
    logic       exp_led;
    logic       exp_tick;
    pat = 8'b1011_0001;
    load_cfg(24'd4, pat, 8'd2);
    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      exp_led  = pat[((k - 1) / 4) % 8] ^ INV;
      exp_tick = ((k - 1) % 4) == 3;
      tests_run++;
      if ({busy, done, tick, led_out} !== {1'b1, 1'b0, exp_tick, exp_led}) begin
        tests_failed++;
        $display("FAIL pattern_run k=%0d got busy/done/tick/led=%b want %b",
                 k, {busy, done, tick, led_out}, {1'b1, 1'b0, exp_tick, exp_led});
      end
      step();
    end
    tests_run++;
    if ({busy, done, tick, led_out} !== {1'b0, 1'b1, 1'b0, INV}) begin
      tests_failed++;
      $display("FAIL pattern_done got busy/done/tick/led=%b want %b",
               {busy, done, tick, led_out}, {1'b0, 1'b1, 1'b0, INV});
    end
    step();
    tests_run++;
    if ({cfg_ready, busy, done} !== 3'b100) begin
      tests_failed++;
      $display("FAIL pattern_after_done got rdy/busy/done=%b want 100", {cfg_ready, busy, done});
    end
    $display("[TB] test_pattern done");
  endtask

  task automatic test_div_clamp();
    logic [7:0] pat;
    logic       exp_led;
    logic       exp_tick;
    pat = 8'h55;
    load_cfg(24'd0, pat, 8'd1);
    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      exp_led  = pat[(k - 1) / 2] ^ INV;
      exp_tick = ((k - 1) % 2) == 1;
      tests_run++;
      if ({busy, done, tick, led_out} !== {1'b1, 1'b0, exp_tick, exp_led}) begin
        tests_failed++;
        $display("FAIL clamp_run k=%0d got busy/done/tick/led=%b want %b",
                 k, {busy, done, tick, led_out}, {1'b1, 1'b0, exp_tick, exp_led});
      end
      step();
    end
    tests_run++;
    if ({busy, done} !== 2'b01) begin
      tests_failed++;
      $display("FAIL clamp_done got busy/done=%b want 01", {busy, done});
    end
    step();
    $display("[TB] test_div_clamp done");
  endtask

  task automatic test_forever_stop();
    logic [7:0] pat;
    logic       exp_led;
    logic       exp_tick;
    pat = 8'hA5;
    load_cfg(24'd3, pat, 8'd0);
    start = 1'b1; step(); start = 1'b0;
    // 7300 cycles is past 300 passes of 24 cycles, so the 8-bit pass counter wraps
    for (int k = 1; k <= 7300; k++) begin
      exp_led  = pat[((k - 1) / 3) % 8] ^ INV;
      exp_tick = ((k - 1) % 3) == 2;
      tests_run++;
      if ({busy, done, tick, led_out} !== {1'b1, 1'b0, exp_tick, exp_led}) begin
        tests_failed++;
        $display("FAIL forever_run k=%0d got busy/done/tick/led=%b want %b",
                 k, {busy, done, tick, led_out}, {1'b1, 1'b0, exp_tick, exp_led});
      end
      step();
    end
    stop = 1'b1; step(); stop = 1'b0;
    tests_run++;
    if ({busy, done, tick, led_out} !== {1'b0, 1'b0, 1'b0, INV}) begin
      tests_failed++;
      $display("FAIL stop_state got busy/done/tick/led=%b want %b",
               {busy, done, tick, led_out}, {1'b0, 1'b0, 1'b0, INV});
    end
    step();
    tests_run++;
    if ({cfg_ready, busy, done} !== 3'b100) begin
      tests_failed++;
      $display("FAIL stop_after got rdy/busy/done=%b want 100", {cfg_ready, busy, done});
    end
    $display("[TB] test_forever_stop done");
  endtask

  task automatic test_cfg_start_same();
    logic exp_led;
    cfg_div = 24'd2; cfg_pattern = 8'h0F; cfg_repeat = 8'd1;
    cfg_valid = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    // Keep offering a different config throughout the run; it must be refused.
    cfg_div = 24'd5; cfg_pattern = 8'hF0; cfg_repeat = 8'd3;
    for (int run = 0; run < 2; run++) begin
      for (int k = 1; k <= 16; k++) begin
        exp_led = (k <= 8) ^ INV;
        tests_run++;
        if ({cfg_ready, busy, done, led_out} !== {1'b0, 1'b1, 1'b0, exp_led}) begin
          tests_failed++;
          $display("FAIL cfgstart_run r=%0d k=%0d got rdy/busy/done/led=%b want %b",
                   run, k, {cfg_ready, busy, done, led_out}, {1'b0, 1'b1, 1'b0, exp_led});
        end
        if (k == 16) cfg_valid = 1'b0;
        step();
      end
      tests_run++;
      if ({cfg_ready, busy, done} !== 3'b001) begin
        tests_failed++;
        $display("FAIL cfgstart_done r=%0d got rdy/busy/done=%b want 001", run, {cfg_ready, busy, done});
      end
      step();
      start = 1'b1; step(); start = 1'b0;
    end
    // The third start above left a run in progress; abort it.
    stop = 1'b1; step(); stop = 1'b0;
    $display("[TB] test_cfg_start_same done");
  endtask

  task automatic test_start_stop_idle();
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    tests_run++;
    if ({busy, led_out} !== {1'b1, 1'b1 ^ INV}) begin
      tests_failed++;
      $display("FAIL start_wins got busy/led=%b want %b", {busy, led_out}, {1'b1, 1'b1 ^ INV});
    end
    stop = 1'b1; step(); stop = 1'b0;
    tests_run++;
    if ({busy, done, led_out} !== {1'b0, 1'b0, INV}) begin
      tests_failed++;
      $display("FAIL stop_abort got busy/done/led=%b want %b", {busy, done, led_out}, {1'b0, 1'b0, INV});
    end
    $display("[TB] test_start_stop_idle done");
  endtask

  task automatic test_reset_midrun();
    int ticks_seen;
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({cfg_ready, busy, done, tick, led_out} !== {1'b1, 1'b0, 1'b0, 1'b0, INV}) begin
      tests_failed++;
      $display("FAIL midrun_reset got rdy/busy/done/tick/led=%b want %b",
               {cfg_ready, busy, done, tick, led_out}, {1'b1, 1'b0, 1'b0, 1'b0, INV});
    end
    step();
    reset_n = 1'b1;
    step();
    tests_run++;
    if ({cfg_ready, busy} !== 2'b10) begin
      tests_failed++;
      $display("FAIL midrun_release got rdy/busy=%b want 10", {cfg_ready, busy});
    end
    // Reset config is all-ones pattern with a very long divide: LED on, no ticks.
    start = 1'b1; step(); start = 1'b0;
    tests_run++;
    if ({busy, led_out} !== {1'b1, 1'b1 ^ INV}) begin
      tests_failed++;
      $display("FAIL default_cfg got busy/led=%b want %b", {busy, led_out}, {1'b1, 1'b1 ^ INV});
    end
    ticks_seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (tick === 1'b1) ticks_seen++;
      step();
    end
    tests_run++;
    if (ticks_seen !== 0) begin
      tests_failed++;
      $display("FAIL default_div got %0d ticks want 0", ticks_seen);
    end
    stop = 1'b1; step(); stop = 1'b0;
    $display("[TB] test_reset_midrun done");
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_div_clamp();
    test_forever_stop();
    test_cfg_start_same();
    test_start_stop_idle();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
